// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller driving a registered-read fifomem.
// The memory read register serves as the output stage, so the consumer sees fall-through timing.
module fifo_sync_ctrl #(
  parameter int unsigned DATASIZE         = 8,
  parameter int unsigned ADDRSIZE         = 4,
  parameter int unsigned ALMOST_FULL_LVL  = 14,
  parameter int unsigned ALMOST_EMPTY_LVL = 2
) (
  input  logic                aclk_i,
  input  logic                srst_i,
  input  logic                flush_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [DATASIZE-1:0] wr_data_i,
  output logic                rd_valid_o,
  input  logic                rd_ready_i,
  output logic [DATASIZE-1:0] rd_data_o,
  output logic [ADDRSIZE:0]   level_o,
  output logic                almost_full_o,
  output logic                almost_empty_o,
  output logic                mem_wclken_o,
  output logic [ADDRSIZE-1:0] mem_waddr_o,
  output logic [DATASIZE-1:0] mem_wdata_o,
  output logic                mem_wfull_o,
  output logic                mem_rclken_o,
  output logic [ADDRSIZE-1:0] mem_raddr_o,
  input  logic [DATASIZE-1:0] mem_rdata_i
);

  localparam logic [0:0] OutEmpty = 1'b0;
  localparam logic [0:0] OutValid = 1'b1;

  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic [ADDRSIZE:0] rptr_q, rptr_d;
  logic [ADDRSIZE:0] ram_cnt;
  logic [0:0]        out_state_q, out_state_d;
  logic              ram_full, ram_empty;
  logic              wr_fire, rd_fire, rd_issue, clr;

  assign clr       = srst_i | flush_i;
  assign ram_full  = (wptr_q[ADDRSIZE] != rptr_q[ADDRSIZE]) &&
                     (wptr_q[ADDRSIZE-1:0] == rptr_q[ADDRSIZE-1:0]);
  assign ram_empty = (wptr_q == rptr_q);
  assign ram_cnt   = wptr_q - rptr_q;

  assign wr_ready_o = ~ram_full;
  assign rd_valid_o = (out_state_q == OutValid);
  assign wr_fire    = wr_valid_i & wr_ready_o;
  assign rd_fire    = rd_valid_o & rd_ready_i;
  // Refill the output register whenever it is empty or being drained this cycle.
  assign rd_issue   = ~ram_empty & (~rd_valid_o | rd_fire);

  assign mem_wclken_o = wr_fire & ~clr;
  assign mem_rclken_o = rd_issue & ~clr;
  assign mem_waddr_o  = wptr_q[ADDRSIZE-1:0];
  assign mem_raddr_o  = rptr_q[ADDRSIZE-1:0];
  assign mem_wdata_o  = wr_data_i;
  assign mem_wfull_o  = ram_full;
  assign rd_data_o    = mem_rdata_i;

  assign level_o        = ram_cnt + {{ADDRSIZE{1'b0}}, rd_valid_o};
  assign almost_full_o  = (32'(level_o) >= ALMOST_FULL_LVL);
  assign almost_empty_o = (32'(level_o) <= ALMOST_EMPTY_LVL);

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    out_state_d = out_state_q;
    if (flush_i) begin
      wptr_d      = '0;
      rptr_d      = '0;
      out_state_d = OutEmpty;
    end else begin
      if (wr_fire) begin
        wptr_d = wptr_q + 1'b1;
      end
      if (rd_issue) begin
        rptr_d      = rptr_q + 1'b1;
        out_state_d = OutValid;
      end else if (rd_fire) begin
        out_state_d = OutEmpty;
      end
    end
  end

  always_ff @(posedge aclk_i) begin
    if (srst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      out_state_q <= OutEmpty;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      out_state_q <= out_state_d;
    end
  end

endmodule
